// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helper for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREGS_DEF  = 16;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a write in flight and their count.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter bit          ZERO_R0 = 1'b0,
    localparam int unsigned AW     = clog2(NREGS),
    localparam int unsigned PW     = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic [AW-1:0] rd_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rd_busy,
    output logic          issue_ok,
    output logic [PW-1:0] pending
);

    logic [NREGS-1:0] r_busy;
    logic [PW-1:0]    r_pending;
    logic [NREGS-1:0] w_busy_eff;
    logic [NREGS-1:0] w_busy_nxt;
    logic [NREGS-1:0] w_rise;
    logic [NREGS-1:0] w_fall;
    logic [PW-1:0]    w_pending_nxt;

    // A writeback clears its bit before lookups; a same-cycle issue then re-sets it.
    always_comb begin
        w_busy_eff = r_busy;
        if (wr_en) begin
            w_busy_eff[wr_addr] = 1'b0;
        end
        w_busy_nxt = w_busy_eff;
        if (issue_en) begin
            w_busy_nxt[issue_addr] = 1'b1;
        end
        if (ZERO_R0) begin
            w_busy_nxt[0] = 1'b0;
        end
        w_rise        = w_busy_nxt & ~r_busy;
        w_fall        = r_busy & ~w_busy_nxt;
        w_pending_nxt = r_pending + PW'(|w_rise) - PW'(|w_fall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign rs1_busy = w_busy_eff[rs1_addr];
    assign rs2_busy = w_busy_eff[rs2_addr];
    assign rd_busy  = w_busy_eff[rd_addr];
    assign issue_ok = ~w_busy_eff[issue_addr];
    assign pending  = r_pending;

endmodule

// File: rtl/regfile_sb.sv
// Three-read register file with write-through bypass and a busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter bit          ZERO_R0 = 1'b0,
    localparam int unsigned AW     = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    output logic              issue_ok,
    output logic [AW:0]       pending
);

    logic [DATA_W-1:0] r_mem [NREGS];
    logic [AW-1:0]     w_raddr [3];
    logic [DATA_W-1:0] w_rdata [3];
    logic              w_wr_mem;

    assign w_wr_mem = wr_en && !(ZERO_R0 && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_mem) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read ports: array, then same-cycle writeback bypass, then hardwired R0.
    always_comb begin
        w_raddr[0] = rs1_addr;
        w_raddr[1] = rs2_addr;
        w_raddr[2] = rd_addr;
        for (int p = 0; p < 3; p++) begin
            w_rdata[p] = r_mem[w_raddr[p]];
            if (wr_en && (wr_addr == w_raddr[p])) begin
                w_rdata[p] = wr_data;
            end
            if (ZERO_R0 && (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
            end
        end
    end

    assign rs1_data = w_rdata[0];
    assign rs2_data = w_rdata[1];
    assign rd_data  = w_rdata[2];

    rf_scoreboard #(
        .NREGS   (NREGS),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rd_busy    (rd_busy),
        .issue_ok   (issue_ok),
        .pending    (pending)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; one instance with plain R0, one with hardwired R0.
module tb_regfile_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic          wr_en, issue_en;
    logic [AW-1:0] wr_addr, issue_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] a_rs1_data, a_rs2_data, a_rd_data;
    logic          a_rs1_busy, a_rs2_busy, a_rd_busy, a_issue_ok;
    logic [AW:0]   a_pending;
    logic [DW-1:0] z_rs1_data, z_rs2_data, z_rd_data;
    logic          z_rs1_busy, z_rs2_busy, z_rd_busy, z_issue_ok;
    logic [AW:0]   z_pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .NREGS(NR), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data), .rd_data(a_rd_data),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy), .rd_busy(a_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .issue_ok(a_issue_ok), .pending(a_pending)
    );

    regfile_sb #(.DATA_W(DW), .NREGS(NR), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(z_rs1_data), .rs2_data(z_rs2_data), .rd_data(z_rd_data),
        .rs1_busy(z_rs1_busy), .rs2_busy(z_rs2_busy), .rd_busy(z_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .issue_ok(z_issue_ok), .pending(z_pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst      = 1'b0;
        wr_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < NR; a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'(a);
            rd_addr  = AW'(a);
            #1;
            checks++;
            if ({a_rs1_data, a_rs2_data, a_rd_data, a_rs1_busy, a_rs2_busy, a_rd_busy} !== '0) begin
                failures++;
                $display("FAIL reset_read addr=%0d got d=%h/%h/%h b=%b%b%b want all 0", a,
                         a_rs1_data, a_rs2_data, a_rd_data, a_rs1_busy, a_rs2_busy, a_rd_busy);
            end
        end
        checks++;
        if (a_pending !== 5'd0 || z_pending !== 5'd0) begin
            failures++;
            $display("FAIL reset_pending got %0d/%0d want 0/0", a_pending, z_pending);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        rs1_addr = 4'd5; rs2_addr = 4'd6;
        #1;
        checks++;
        if (a_rs1_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_same_cycle got %h want deadbeef", a_rs1_data);
        end
        checks++;
        if (a_rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL bypass_other_addr got %h want 0", a_rs2_data);
        end
        tick();
        wr_en = 1'b0; rs2_addr = 4'd5;
        #1;
        checks++;
        if (a_rs2_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL stored_read got %h want deadbeef", a_rs2_data);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_en = 1'b1; issue_addr = 4'd3;
        tick();
        issue_addr = 4'd7;
        tick();
        issue_en = 1'b0; issue_addr = 4'd3; rs1_addr = 4'd3;
        #1;
        checks++;
        if (a_pending !== 5'd2) begin
            failures++;
            $display("FAIL sb_pending2 got %0d want 2", a_pending);
        end
        checks++;
        if (a_rs1_busy !== 1'b1 || a_issue_ok !== 1'b0) begin
            failures++;
            $display("FAIL sb_busy3 got busy=%b ok=%b want busy=1 ok=0", a_rs1_busy, a_issue_ok);
        end
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h11;
        #1;
        checks++;
        if (a_rs1_busy !== 1'b0 || a_issue_ok !== 1'b1) begin
            failures++;
            $display("FAIL sb_clear_bypass got busy=%b ok=%b want busy=0 ok=1", a_rs1_busy, a_issue_ok);
        end
        tick();
        wr_en = 1'b0; issue_addr = 4'd7;
        #1;
        checks++;
        if (a_pending !== 5'd1 || a_rs1_data !== 32'h11 || a_issue_ok !== 1'b0) begin
            failures++;
            $display("FAIL sb_after_wb got pend=%0d d=%h ok7=%b want 1/00000011/0",
                     a_pending, a_rs1_data, a_issue_ok);
        end
    endtask

    task automatic test_same_cycle();
        // busy = {7}, pending = 1
        idle();
        issue_en = 1'b1; issue_addr = 4'd4; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h22;
        tick();
        idle();
        rs1_addr = 4'd4;
        #1;
        checks++;
        if (a_rs1_data !== 32'h22 || a_rs1_busy !== 1'b1 || a_pending !== 5'd2) begin
            failures++;
            $display("FAIL same_cycle_idle got d=%h b=%b p=%0d want 22/1/2", a_rs1_data, a_rs1_busy, a_pending);
        end
        issue_en = 1'b1; issue_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h33;
        tick();
        idle();
        rs2_addr = 4'd7;
        #1;
        checks++;
        if (a_rs2_data !== 32'h33 || a_rs2_busy !== 1'b1 || a_pending !== 5'd2) begin
            failures++;
            $display("FAIL same_cycle_busy got d=%h b=%b p=%0d want 33/1/2", a_rs2_data, a_rs2_busy, a_pending);
        end
    endtask

    task automatic test_waw_and_idle_write();
        // busy = {4,7}, pending = 2
        idle();
        issue_en = 1'b1; issue_addr = 4'd4;
        #1;
        checks++;
        if (a_issue_ok !== 1'b0) begin
            failures++;
            $display("FAIL waw_issue_ok got %b want 0", a_issue_ok);
        end
        tick();
        idle();
        rd_addr = 4'd4;
        #1;
        checks++;
        if (a_pending !== 5'd2 || a_rd_busy !== 1'b1) begin
            failures++;
            $display("FAIL waw_state got p=%0d b=%b want 2/1", a_pending, a_rd_busy);
        end
        wr_en = 1'b1; wr_addr = 4'd10; wr_data = 32'h55;
        tick();
        idle();
        rd_addr = 4'd10;
        #1;
        checks++;
        if (a_pending !== 5'd2 || a_rd_busy !== 1'b0 || a_rd_data !== 32'h55) begin
            failures++;
            $display("FAIL idle_write got p=%0d b=%b d=%h want 2/0/55", a_pending, a_rd_busy, a_rd_data);
        end
    endtask

    task automatic test_zero_r0();
        do_reset();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFF;
        issue_en = 1'b1; issue_addr = 4'd0; rs1_addr = 4'd0;
        #1;
        checks++;
        if (z_rs1_data !== 32'h0 || a_rs1_data !== 32'hFF || z_issue_ok !== 1'b1) begin
            failures++;
            $display("FAIL r0_bypass got z=%h a=%h zok=%b want 0/ff/1", z_rs1_data, a_rs1_data, z_issue_ok);
        end
        tick();
        idle();
        #1;
        checks++;
        if (z_rs1_data !== 32'h0 || z_rs1_busy !== 1'b0 || z_pending !== 5'd0) begin
            failures++;
            $display("FAIL r0_zero got d=%h b=%b p=%0d want 0/0/0", z_rs1_data, z_rs1_busy, z_pending);
        end
        checks++;
        if (a_rs1_data !== 32'hFF || a_rs1_busy !== 1'b1 || a_pending !== 5'd1) begin
            failures++;
            $display("FAIL r0_plain got d=%h b=%b p=%0d want ff/1/1", a_rs1_data, a_rs1_busy, a_pending);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_en = 1'b1;
        issue_addr = 4'd1; tick();
        issue_addr = 4'd2; tick();
        issue_addr = 4'd9; tick();
        idle();
        #1;
        checks++;
        if (a_pending !== 5'd3) begin
            failures++;
            $display("FAIL mid_pending3 got %0d want 3", a_pending);
        end
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h77; rs1_addr = 4'd2;
        #1;
        checks++;
        if (a_rs1_data !== 32'h77 || a_rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_bypass got d=%h b=%b want 77/0", a_rs1_data, a_rs1_busy);
        end
        tick();
        idle();
        rs1_addr = 4'd1; rs2_addr = 4'd2; rd_addr = 4'd9;
        #1;
        checks++;
        if (a_pending !== 5'd0 || a_rs2_data !== 32'h0 ||
            {a_rs1_busy, a_rs2_busy, a_rd_busy} !== 3'b000) begin
            failures++;
            $display("FAIL mid_cleared got p=%0d r2=%h b=%b%b%b want 0/0/000",
                     a_pending, a_rs2_data, a_rs1_busy, a_rs2_busy, a_rd_busy);
        end
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99;
        tick();
        idle();
        #1;
        checks++;
        if (a_pending !== 5'd0 || a_rd_busy !== 1'b0 || a_rd_data !== 32'h99) begin
            failures++;
            $display("FAIL mid_late_wb got p=%0d b=%b d=%h want 0/0/99", a_pending, a_rd_busy, a_rd_data);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; issue_en = 1'b0;
        wr_addr = '0; wr_data = '0; issue_addr = '0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        tick();
        test_reset();
        test_bypass();
        test_scoreboard();
        test_same_cycle();
        test_waw_and_idle_write();
        test_zero_r0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
